// File: rtl/async_queue_pkg.sv
// rtl/async_queue_pkg.sv - shared constants, ratio helper and stats types for the async queue write side
package async_queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int STATS_CNT_WIDTH    = 16;

  function automatic int calc_ratio(input int data_width, input int in_width);
    return data_width / in_width;
  endfunction

  typedef struct packed {
    logic [STATS_CNT_WIDTH-1:0] word_cnt;
    logic [STATS_CNT_WIDTH-1:0] pad_cnt;
    logic [STATS_CNT_WIDTH-1:0] stall_cnt;
  } stats_t;

  function automatic logic [STATS_CNT_WIDTH-1:0] sat_inc(input logic [STATS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/async_queue_wr_packer.sv
// rtl/async_queue_wr_packer.sv - packs narrow beats into FIFO words and throttles writes against a registered full flag
// Optional statistics counters: define ASYNC_QUEUE_WR_PACKER_STATS_EN.
module async_queue_wr_packer
  import async_queue_pkg::*;
#(
  parameter int IN_WIDTH   = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = STATS_CNT_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pad_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  localparam int RATIO  = calc_ratio(DATA_WIDTH, IN_WIDTH);
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  generate
    if (RATIO < 2 || (DATA_WIDTH % IN_WIDTH) != 0) begin : g_bad_ratio
      $error("async_queue_wr_packer: DATA_WIDTH must be an integer multiple (>=2) of IN_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] wd;
  logic [LANE_W-1:0]     lane;
  logic                  pending;
  logic                  wr_en_q;

  logic                  accept;
  logic                  complete;
  logic [DATA_WIDTH-1:0] merged;

  // wr_en_q blocks the cycle after a write, when full does not yet reflect it
  assign wr_en    = pending && !full && !wr_en_q;
  assign wr_data  = wd;
  assign in_ready = !pending || wr_en;

  assign accept   = in_valid && in_ready;
  assign complete = accept && ((lane == LAST_LANE) || in_last);
  assign merged   = acc | ({{(DATA_WIDTH-IN_WIDTH){1'b0}}, in_data} << (int'(lane) * IN_WIDTH));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      acc     <= '0;
      lane    <= '0;
      pending <= 1'b0;
      wd      <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en;
      if (complete) begin
        wd      <= merged;
        pending <= 1'b1;
        acc     <= '0;
        lane    <= '0;
      end else begin
        if (accept) begin
          acc  <= merged;
          lane <= lane + LANE_W'(1);
        end
        if (wr_en) pending <= 1'b0;
      end
    end
  end

`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
  generate
    if (CNT_WIDTH != STATS_CNT_WIDTH) begin : g_bad_cnt
      $error("async_queue_wr_packer: CNT_WIDTH must match STATS_CNT_WIDTH");
    end
  endgenerate

  stats_t stats;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      stats <= '0;
    end else begin
      if (wr_en) stats.word_cnt <= sat_inc(stats.word_cnt);
      if (complete && in_last && (lane != LAST_LANE)) stats.pad_cnt <= sat_inc(stats.pad_cnt);
      if (pending && full) stats.stall_cnt <= sat_inc(stats.stall_cnt);
    end
  end

  assign word_cnt  = stats.word_cnt;
  assign pad_cnt   = stats.pad_cnt;
  assign stall_cnt = stats.stall_cnt;
`endif

endmodule

// File: tb/tb_async_queue_wr_packer.sv
// tb/tb_async_queue_wr_packer.sv - scoreboard bench for async_queue_wr_packer with a beat-list reference model
module tb_async_queue_wr_packer;

  localparam int IW    = 4;
  localparam int DW    = 8;
  localparam int RATIO = DW / IW;
  localparam int CW    = 16;

  logic          wr_clk = 1'b0;
  logic          wr_rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          full = 1'b0;
  logic          wr_en;
  logic [DW-1:0] wr_data;
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
  logic [CW-1:0] word_cnt, pad_cnt, stall_cnt;
  int            exp_words = 0, exp_pads = 0, exp_stalls = 0;
`endif

  async_queue_wr_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .full     (full),
    .wr_en    (wr_en),
    .wr_data  (wr_data)
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
    ,
    .word_cnt (word_cnt),
    .pad_cnt  (pad_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];
  logic [IW-1:0] cur[$];
  logic          prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack_beats();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < cur.size(); i++) w = w | (DW'(cur[i]) << (i * IW));
    return w;
  endfunction

  // Input-side model: words held = completed beats not yet written
  always @(negedge wr_clk) begin
    if (!wr_rst_n) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_data", wr_data, 0);
      sb.delete();
      cur.delete();
      prev_wr = 1'b0;
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
      exp_words = 0; exp_pads = 0; exp_stalls = 0;
`endif
    end else begin
      chk("wr_en_rule", wr_en, (sb.size() > 0) && !full && !prev_wr);
      chk("in_ready_rule", in_ready, (sb.size() == 0) || wr_en);
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
      if (sb.size() > 0 && full) exp_stalls++;
`endif
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == RATIO || in_last) begin
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
          if (cur.size() < RATIO) exp_pads++;
`endif
          sb.push_back(pack_beats());
          cur.delete();
        end
      end
      prev_wr = wr_en;
    end
  end

  // Output monitor: every FIFO write must match the oldest expected word
  always @(negedge wr_clk) begin
    #1;
    if (wr_rst_n && wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("wr_data", wr_data, sb.pop_front());
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
        exp_words++;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge wr_clk);
      n++;
    end while (!in_ready && n < 60);
    if (!in_ready) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    wr_rst_n = 1'b1;
    tick();

    send(4'h3, 0); send(4'h5, 0);
    repeat (3) tick();
    for (int i = 1; i <= 8; i++) send(IW'(i), 0);
    repeat (3) tick();
    send(4'hA, 1);
    repeat (3) tick();

    full = 1'b1;
    send(4'h1, 0); send(4'h2, 0);
    in_valid = 1'b1; in_data = 4'h3; in_last = 1'b0;
    repeat (10) tick();
    full = 1'b0;
    send(4'h3, 0); send(4'h4, 0);
    repeat (4) tick();

    send(4'h7, 0);
    wr_rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) tick();
    wr_rst_n = 1'b1;
    tick();
    send(4'h1, 0); send(4'h2, 0);
    repeat (3) tick();

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = IW'($urandom);
      in_last  = ($urandom_range(4) == 0);
      if ($urandom_range(7) == 0) full = ~full;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; full = 1'b0;
    repeat (20) tick();
    chk("drain_empty", sb.size(), 0);
`ifdef ASYNC_QUEUE_WR_PACKER_STATS_EN
    chk("word_cnt", word_cnt, exp_words);
    chk("pad_cnt", pad_cnt, exp_pads);
    chk("stall_cnt", stall_cnt, exp_stalls);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
